// File: rtl/subcounter.sv
// Presettable synchronous down counter with cascade borrow, registered terminal-count pulse
// and optional auto-reload from D on underflow (divide-by-(D+1)).
module subcounter #(
  parameter int unsigned WIDTH = 4,
  parameter bit          BCD   = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic             p,
  input  logic             t,
  input  logic             ar,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             bo,
  output logic             tc
);

  // Value taken after underflow when not auto-reloading.
  localparam logic [WIDTH-1:0] MaxVal = BCD ? WIDTH'(9) : {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             is_zero;

  assign is_zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (!ld) begin
      cnt_d = D;
    end else if (p && t) begin
      if (!is_zero) begin
        // Out-of-range BCD values simply decrement toward 9.
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d = ar ? D : MaxVal;
        tc_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign Q  = cnt_q;
  assign tc = tc_q;
  // Lookahead for the next stage: must not wait for a register.
  assign bo = t & is_zero;

endmodule

// File: tb/tb_subcounter.sv
// Directed bench for subcounter: binary, BCD, auto-reload, priority and a two-digit BCD cascade.
module tb_subcounter;

  logic       clk = 1'b0;
  logic       clr;
  always #5 clk = ~clk;

  // Binary stage
  logic       ld, p, t, ar;
  logic [3:0] d, q;
  logic       bo, tc;

  // Single BCD stage
  logic       ld_b, p_b, t_b;
  logic [3:0] d_b, q_b;
  logic       bo_b, tc_b;

  // Two-digit BCD cascade
  logic       ld_c, p_c, t_c;
  logic [3:0] d0_c, d1_c, q0_c, q1_c;
  logic       bo0_c, bo1_c, tc0_c, tc1_c;

  int passed = 0;
  int total  = 0;
  int exp_q;
  int exp_tc;
  int exp_v;

  subcounter #(.WIDTH(4), .BCD(1'b0)) u_bin (
    .clk(clk), .clr(clr), .ld(ld), .p(p), .t(t), .ar(ar), .D(d), .Q(q), .bo(bo), .tc(tc)
  );

  subcounter #(.WIDTH(4), .BCD(1'b1)) u_bcd (
    .clk(clk), .clr(clr), .ld(ld_b), .p(p_b), .t(t_b), .ar(1'b0), .D(d_b), .Q(q_b),
    .bo(bo_b), .tc(tc_b)
  );

  subcounter #(.WIDTH(4), .BCD(1'b1)) u_c0 (
    .clk(clk), .clr(clr), .ld(ld_c), .p(p_c), .t(t_c), .ar(1'b0), .D(d0_c), .Q(q0_c),
    .bo(bo0_c), .tc(tc0_c)
  );

  subcounter #(.WIDTH(4), .BCD(1'b1)) u_c1 (
    .clk(clk), .clr(clr), .ld(ld_c), .p(p_c), .t(bo0_c), .ar(1'b0), .D(d1_c), .Q(q1_c),
    .bo(bo1_c), .tc(tc1_c)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0;
    ld = 1'b1; p = 1'b0; t = 1'b0; ar = 1'b0; d = 4'd0;
    ld_b = 1'b1; p_b = 1'b0; t_b = 1'b0; d_b = 4'd0;
    ld_c = 1'b1; p_c = 1'b0; t_c = 1'b0; d0_c = 4'd0; d1_c = 4'd1;
    #3;
    check("reset_q", 8'(q), 8'd0);
    check("reset_tc", 8'(tc), 8'd0);
    clr = 1'b1;

    // Async clear between edges
    ld = 1'b0; d = 4'd5;
    step();
    check("load5", 8'(q), 8'd5);
    ld = 1'b1; t = 1'b1;
    #2 clr = 1'b0;
    #1;
    check("async_clr_q", 8'(q), 8'd0);
    check("async_clr_tc", 8'(tc), 8'd0);
    check("async_clr_bo", 8'(bo), 8'd1);
    clr = 1'b1;
    step();

    // Binary wrap
    ld = 1'b0; d = 4'd3; t = 1'b0;
    step();
    check("bin_load", 8'(q), 8'd3);
    ld = 1'b1; p = 1'b1; t = 1'b1;
    check("bin_bo_3", 8'(bo), 8'd0);
    step(); check("bin_q2", 8'(q), 8'd2);
    step(); check("bin_q1", 8'(q), 8'd1);
    step(); check("bin_q0", 8'(q), 8'd0);
    check("bin_bo_0", 8'(bo), 8'd1);
    check("bin_tc_0", 8'(tc), 8'd0);
    step(); check("bin_q15", 8'(q), 8'd15);
    check("bin_tc_15", 8'(tc), 8'd1);
    check("bin_bo_15", 8'(bo), 8'd0);
    step(); check("bin_q14", 8'(q), 8'd14);
    check("bin_tc_14", 8'(tc), 8'd0);

    // Auto-reload divide-by-5
    ar = 1'b1; ld = 1'b0; d = 4'd4;
    step();
    check("ar_load", 8'(q), 8'd4);
    ld = 1'b1;
    exp_q = 4;
    for (int i = 0; i < 15; i++) begin
      exp_tc = (exp_q == 0) ? 1 : 0;
      exp_q  = (exp_q == 0) ? 4 : exp_q - 1;
      step();
      check("ar_q", 8'(q), 8'(exp_q));
      check("ar_tc", 8'(tc), 8'(exp_tc));
    end

    // Auto-reload with D = 0
    ld = 1'b0; d = 4'd0;
    step();
    check("ar0_load_tc", 8'(tc), 8'd0);
    ld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar0_q", 8'(q), 8'd0);
      check("ar0_tc", 8'(tc), 8'd1);
    end

    // Enables and priority at Q = 0
    ar = 1'b0; p = 1'b0; t = 1'b1;
    step();
    check("hold_q", 8'(q), 8'd0);
    check("hold_bo", 8'(bo), 8'd1);
    check("hold_tc", 8'(tc), 8'd0);
    t = 1'b0; p = 1'b1;
    #1;
    check("t0_bo", 8'(bo), 8'd0);
    step();
    check("t0_hold_q", 8'(q), 8'd0);
    t = 1'b1; ld = 1'b0; d = 4'd7;
    step();
    check("ld_prio_q", 8'(q), 8'd7);
    check("ld_prio_tc", 8'(tc), 8'd0);
    ld = 1'b1; p = 1'b0;

    // BCD wrap
    ld_b = 1'b0; d_b = 4'd2;
    step();
    check("bcd_load2", 8'(q_b), 8'd2);
    ld_b = 1'b1; p_b = 1'b1; t_b = 1'b1;
    step(); check("bcd_q1", 8'(q_b), 8'd1);
    step(); check("bcd_q0", 8'(q_b), 8'd0);
    check("bcd_tc0", 8'(tc_b), 8'd0);
    step(); check("bcd_q9", 8'(q_b), 8'd9);
    check("bcd_tc9", 8'(tc_b), 8'd1);
    step(); check("bcd_q8", 8'(q_b), 8'd8);
    check("bcd_tc8", 8'(tc_b), 8'd0);
    ld_b = 1'b0; d_b = 4'd12;
    step();
    check("bcd_load12", 8'(q_b), 8'd12);
    ld_b = 1'b1;
    for (int v = 11; v >= 9; v--) begin
      step();
      check("bcd_oor_q", 8'(q_b), 8'(v));
      check("bcd_oor_tc", 8'(tc_b), 8'd0);
    end
    p_b = 1'b0;

    // Two-digit BCD cascade: 10 -> 09 -> ... -> 00 -> 99
    ld_c = 1'b0;
    step();
    check("casc_load", 8'(q1_c * 10 + q0_c), 8'd10);
    ld_c = 1'b1; p_c = 1'b1; t_c = 1'b1;
    exp_v = 10;
    for (int i = 0; i < 11; i++) begin
      exp_v = (exp_v == 0) ? 99 : exp_v - 1;
      step();
      check("casc_val", 8'(q1_c * 10 + q0_c), 8'(exp_v));
    end
    check("casc_tc0", 8'(tc0_c), 8'd1);
    check("casc_tc1", 8'(tc1_c), 8'd1);
    step();
    check("casc_98", 8'(q1_c * 10 + q0_c), 8'd98);
    check("casc_tc1_off", 8'(tc1_c), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/subcounter.md
# subcounter

Presettable synchronous down counter: the counting-down counterpart of the team's 74161-style up counter. Same control set: async clear, sync active-low load, P/T count enables. Adds a combinational borrow output for ripple cascading of stages, a registered terminal-count pulse, and an optional auto-reload mode that lets one stage act as a programmable divide-by-(D+1). Used in lab designs for countdown timers, multi-digit BCD down counters and frequency dividers.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..16.
- BCD, 0, 1 = decade counting (9..0); requires WIDTH = 4. 0 = binary (2^WIDTH-1..0).
- clk  input  1  clock; all state changes on rising edge.
- clr  input  1  reset, asynchronous, active-low; clock clk.
- ld  input  1  synchronous parallel load, active-low.
- p  input  1  count enable (local).
- t  input  1  count enable (cascade); also gates bo.
- ar  input  1  auto-reload: on underflow, reload from D instead of wrapping.
- D  input  WIDTH  parallel load / reload value.
- Q  output  WIDTH  counter state, registered.
- bo  output  1  borrow out, combinational: t & (Q == 0).
- tc  output  1  terminal-count pulse, registered, high for one cycle after each underflow step.

## Operation
- MAX = 9 if BCD else 2^WIDTH-1.
- Priority per rising edge: clr low (async) > ld low > count (p & t) > hold.
- clr low: Q = 0, tc = 0 immediately, independent of clk; held while clr low.
- ld low: Q <= D (any value, including D > 9 in BCD mode); tc <= 0. p, t, ar ignored.
- Count (ld high, p = t = 1):
  - Q != 0: Q <= Q - 1; tc <= 0.
  - Q == 0, ar = 0: Q <= MAX; tc <= 1.
  - Q == 0, ar = 1: Q <= D; tc <= 1.
- Hold (ld high, p & t = 0): Q unchanged; tc <= 0.
- BCD mode with out-of-range Q (10..15 after load): decrement normally (15 -> 14 -> ... -> 9); no forced correction.
- Auto-reload with D = 0: Q stays 0, tc high every enabled cycle (divide-by-1).
- Cascade: stage n's t driven from stage n-1's bo; all stages share clk, clr, ld, p. Upper stage steps only on the cycle the lower stage underflows.
- bo depends on current Q and t only; not on p, ld or ar.

## Timing
- Reset values: Q = 0, tc = 0; bo = t (Q is 0).
- Load and count latency: 1 cycle (Q valid after the edge at which the condition was sampled).
- tc: asserted the cycle immediately after the underflow edge; exactly one cycle wide per underflow; continuous high only under repeated underflow (MAX/D = 0 cases).
- bo: combinational, no register delay; valid within the same cycle Q reaches 0 (it is the lookahead for the next stage).
- clr deassertion: first count/load takes effect at the first rising edge with clr high; no edge is lost or double-counted.
- clr asserted mid-count or mid-load: Q and tc forced to 0 without waiting for clk.
- ld low together with p = t = 1 at Q = 0: load wins; tc <= 0.

## Test plan
- Reset: clr = 0 async between edges with Q = 5 -> Q = 0, tc = 0 immediately; with t = 1, bo = 1.
- Binary wrap (WIDTH = 4, BCD = 0): load D = 3, p = t = 1, ar = 0 -> Q = 3,2,1,0,15,14; bo high only while Q = 0; tc high only on the cycle Q = 15.
- BCD wrap: load 2, count -> 2,1,0,9,8; load 12, count -> 12,11,10,9; tc only after the 0 -> 9 step.
- Auto-reload divider: D = 4, ar = 1, load then count 15 cycles -> Q sequence 4,3,2,1,0 repeating; tc pulses every 5 cycles; D = 0 -> tc constantly high.
- Enables/priority: p = 0, t = 1 at Q = 0 -> Q holds, bo = 1, tc = 0; t = 0 -> bo = 0; ld = 0 with p = t = 1 at Q = 0 -> Q = D, tc = 0.
- Two-stage BCD cascade (stage 1 t = stage 0 bo): load 10 (digits 1,0), count -> 10, 09, 08, ..., 00, 99; upper digit steps only on the lower digit's underflow edge.
